fp_compare_unit: RTL and testbench
==================================

FP_COMPARE_UNIT -- requirements
Module: fp_compare_unit

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent width.
REQ-002 SHALL have parameter MAN_W, default 23, mantissa width; operand width W = 1+EXP_W+MAN_W.
REQ-003 SHALL have one clock and a synchronous, active-high reset: clk input 1 (rising-edge clock); rst input 1 (synchronous active-high reset).
REQ-004 SHALL have port in_valid, input, 1: request valid.
REQ-005 SHALL have port in_ready, output, 1: unit accepts request this cycle.
REQ-006 SHALL have port op_a, input, W: operand a (sign, exponent, mantissa).
REQ-007 SHALL have port op_b, input, W: operand b.
REQ-008 SHALL have port op, input, 3: 000 FLE, 001 FLT, 010 FEQ, 011 FMIN, 100 FMAX, 101 FCLASS, others reserved.
REQ-009 SHALL have port out_valid, output, 1: result valid.
REQ-010 SHALL have port out_ready, input, 1: consumer accepts result.
REQ-011 SHALL have port result, output, W: compare bit in [0], or min/max value, or class mask.
REQ-012 SHALL have port flag_nv, output, 1: invalid-operation flag for the presented result.
REQ-013 SHALL have port nv_count, output, 16: saturating count of accepted results with flag_nv=1.

Function
REQ-014 SHALL decode per operand: NaN (exp all ones, mantissa != 0); sNaN (NaN, mantissa MSB 0); infinity; zero; subnormal.
REQ-015 SHALL order non-NaN values: sign differs, negative is less, except +0 == -0 for FLE/FLT/FEQ; same sign compares exp and mantissa as magnitude, with the order inverted when negative.
REQ-016 FEQ SHALL return 1 iff the values are equal; any NaN gives 0; flag_nv=1 only if either operand is an sNaN.
REQ-017 FLT/FLE SHALL return a<b / a<=b in result[0] with result[W-1:1]=0; any NaN gives 0 and flag_nv=1.
REQ-018 FMIN/FMAX SHALL return the smaller/larger operand, treating -0 as less than +0.
REQ-019 For FMIN/FMAX with exactly one NaN, the unit SHALL return the other operand.
REQ-020 For FMIN/FMAX with both operands NaN, the unit SHALL return the canonical NaN: sign 0, exp all ones, mantissa MSB only.
REQ-021 For FMIN/FMAX, the unit SHALL set flag_nv=1 if either operand is an sNaN.
REQ-022 Reserved op codes SHALL produce result=0 and flag_nv=0, and SHALL still complete the handshake.
REQ-023 The unit SHALL be a 2-stage pipeline: stage 1 registers decode and magnitude compare; stage 2 registers result and flag_nv.
REQ-024 With out_ready held 1, latency SHALL be 2 cycles from accept (in_valid and in_ready) to out_valid, at a throughput of 1 per cycle.
REQ-025 in_ready SHALL equal !s1_valid || !s2_valid || out_ready (combinational), and SHALL NOT depend on in_valid.
REQ-026 While out_valid=1 and out_ready=0, result and flag_nv SHALL hold stable and no stage whose successor is full SHALL advance.
REQ-027 Results SHALL leave in acceptance order, with no loss or duplication under any backpressure pattern.
REQ-028 nv_count SHALL increment on each output handshake (out_valid and out_ready) with flag_nv=1, and SHALL saturate at 16'hFFFF.

Reset
REQ-029 On rst=1 at a clk edge, all stage valids, out_valid, result, flag_nv and nv_count SHALL become 0.
REQ-030 Reset mid-operation SHALL discard in-flight requests; in_ready SHALL be 1 in the first cycle after reset.
REQ-031 Inputs sampled in a cycle with rst=1 SHALL be ignored.

Configuration
REQ-032 Macro FPCMP_FCLASS_EN, when defined, SHALL enable op 101 (FCLASS): a 10-bit one-hot class of op_a in result[9:0], upper bits 0, flag_nv=0.
REQ-033 FCLASS bit order SHALL be: -inf, -normal, -subnormal, -0, +0, +subnormal, +normal, +inf, sNaN, qNaN.
REQ-034 When FPCMP_FCLASS_EN is undefined, the unit SHALL treat op 101 as reserved per REQ-022 and SHALL synthesise no classify-encoding logic.

Verification
REQ-035 FLT, a=32'hBF800000, b=32'h3F800000, out_ready=1 -> result=32'h1 two cycles after accept, flag_nv=0.
REQ-036 FEQ and FLE, a=32'h00000000, b=32'h80000000 -> result=32'h1 for both, flag_nv=0.
REQ-037 FLT, a=32'h7FC00000, b=32'h3F800000 -> result=0, flag_nv=1, nv_count 0->1; FEQ with the same operands -> result=0, flag_nv=0.
REQ-038 FMIN, a=32'h7F800001 (sNaN), b=32'h40000000 -> result=32'h40000000, flag_nv=1; FMAX with both operands 32'h7FC00000 -> result=32'h7FC00000.
REQ-039 Backpressure: out_ready=0, in_valid=1 for 3 cycles -> 2 accepted, then in_ready=0 and result stable; out_ready=1 -> 3 results in order, none lost or duplicated.
REQ-040 FCLASS, a=32'hFF800000 -> result=32'h001 with FPCMP_FCLASS_EN defined; result=0 and flag_nv=0 without it.

Source files
------------

// File: rtl/fp_compare_unit.sv
// Two-stage IEEE-754 compare/min/max unit with valid/ready handshaking and a saturating invalid counter.
// Optional FCLASS support is compiled in when FPCMP_FCLASS_EN is defined.
module fp_compare_unit #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   op_a,
  input  logic [EXP_W+MAN_W:0]   op_b,
  input  logic [2:0]             op,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   flag_nv,
  output logic [15:0]            nv_count
);
  localparam int W = 1 + EXP_W + MAN_W;

  typedef enum logic [2:0] {
    OP_FLE    = 3'b000,
    OP_FLT    = 3'b001,
    OP_FEQ    = 3'b010,
    OP_FMIN   = 3'b011,
    OP_FMAX   = 3'b100,
    OP_FCLASS = 3'b101
  } op_e;

  // Operand decode
  logic a_exp_ones, b_exp_ones, a_man_nz, b_man_nz;
  logic a_nan, b_nan, a_snan, b_snan, a_zero, b_zero;
  logic mag_lt, mag_eq, lt_tot_d, lt_ord_d, eq_ord_d;

  always_comb begin
    a_exp_ones = &op_a[W-2:MAN_W];
    b_exp_ones = &op_b[W-2:MAN_W];
    a_man_nz   = |op_a[MAN_W-1:0];
    b_man_nz   = |op_b[MAN_W-1:0];
    a_nan      = a_exp_ones & a_man_nz;
    b_nan      = b_exp_ones & b_man_nz;
    a_snan     = a_nan & ~op_a[MAN_W-1];
    b_snan     = b_nan & ~op_b[MAN_W-1];
    a_zero     = ~|op_a[W-2:0];
    b_zero     = ~|op_b[W-2:0];
    mag_lt     = op_a[W-2:0] < op_b[W-2:0];
    mag_eq     = op_a[W-2:0] == op_b[W-2:0];
    // Total order (-0 < +0) for min/max; the ordered relations then fold the zeros together.
    if (op_a[W-1] != op_b[W-1]) lt_tot_d = op_a[W-1];
    else if (op_a[W-1])         lt_tot_d = ~mag_lt & ~mag_eq;
    else                        lt_tot_d = mag_lt;
    lt_ord_d = lt_tot_d & ~(a_zero & b_zero);
    eq_ord_d = (op_a == op_b) | (a_zero & b_zero);
  end

`ifdef FPCMP_FCLASS_EN
  logic [9:0] class_d;
  logic       a_exp_zero;

  always_comb begin
    a_exp_zero = ~|op_a[W-2:MAN_W];
    class_d    = '0;
    if (a_nan)                     class_d[a_snan ? 8 : 9] = 1'b1;
    else if (a_exp_ones)           class_d[op_a[W-1] ? 0 : 7] = 1'b1;
    else if (a_zero)               class_d[op_a[W-1] ? 3 : 4] = 1'b1;
    else if (a_exp_zero)           class_d[op_a[W-1] ? 2 : 5] = 1'b1;
    else                           class_d[op_a[W-1] ? 1 : 6] = 1'b1;
  end
`endif

  // Stage 1 registers
  logic         s1_valid_q, s2_valid_q;
  logic [W-1:0] s1_a_q, s1_b_q;
  op_e          s1_op_q;
  logic         s1_anan_q, s1_bnan_q, s1_asnan_q, s1_bsnan_q;
  logic         s1_lt_tot_q, s1_lt_q, s1_eq_q;
`ifdef FPCMP_FCLASS_EN
  logic [9:0]   s1_class_q;
`endif

  // Stage 2 result formation
  logic [W-1:0] result_d, result_q, canon_nan;
  logic         flag_nv_d, flag_nv_q, any_nan, any_snan;
  logic [15:0]  nv_count_q;

  always_comb begin
    canon_nan            = '0;
    canon_nan[W-2:MAN_W] = '1;
    canon_nan[MAN_W-1]   = 1'b1;
    any_nan              = s1_anan_q | s1_bnan_q;
    any_snan             = s1_asnan_q | s1_bsnan_q;
    result_d             = '0;
    flag_nv_d            = 1'b0;
    case (s1_op_q)
      OP_FLE: begin
        result_d[0] = ~any_nan & (s1_lt_q | s1_eq_q);
        flag_nv_d   = any_nan;
      end
      OP_FLT: begin
        result_d[0] = ~any_nan & s1_lt_q;
        flag_nv_d   = any_nan;
      end
      OP_FEQ: begin
        result_d[0] = ~any_nan & s1_eq_q;
        flag_nv_d   = any_snan;
      end
      OP_FMIN, OP_FMAX: begin
        flag_nv_d = any_snan;
        if (s1_anan_q && s1_bnan_q) result_d = canon_nan;
        else if (s1_anan_q)         result_d = s1_b_q;
        else if (s1_bnan_q)         result_d = s1_a_q;
        else if ((s1_op_q == OP_FMIN) == s1_lt_tot_q) result_d = s1_a_q;
        else                        result_d = s1_b_q;
      end
`ifdef FPCMP_FCLASS_EN
      OP_FCLASS: result_d[9:0] = s1_class_q;
`endif
      default: ;
    endcase
  end

  logic s2_adv;
  assign s2_adv    = ~s2_valid_q | out_ready;
  assign in_ready  = ~s1_valid_q | ~s2_valid_q | out_ready;
  assign out_valid = s2_valid_q;
  assign result    = result_q;
  assign flag_nv   = flag_nv_q;
  assign nv_count  = nv_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      result_q   <= '0;
      flag_nv_q  <= 1'b0;
      nv_count_q <= '0;
    end else begin
      if (s2_adv) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          result_q  <= result_d;
          flag_nv_q <= flag_nv_d;
        end
      end
      if (in_ready) s1_valid_q <= in_valid;
      if (in_valid && in_ready) begin
        s1_a_q      <= op_a;
        s1_b_q      <= op_b;
        s1_op_q     <= op_e'(op);
        s1_anan_q   <= a_nan;
        s1_bnan_q   <= b_nan;
        s1_asnan_q  <= a_snan;
        s1_bsnan_q  <= b_snan;
        s1_lt_tot_q <= lt_tot_d;
        s1_lt_q     <= lt_ord_d;
        s1_eq_q     <= eq_ord_d;
`ifdef FPCMP_FCLASS_EN
        s1_class_q  <= class_d;
`endif
      end
      if (s2_valid_q && out_ready && flag_nv_q && (nv_count_q != '1))
        nv_count_q <= nv_count_q + 16'd1;
    end
  end
endmodule

// File: tb/tb_fp_compare_unit.sv
// Directed + randomised scoreboard bench for fp_compare_unit (single precision defaults).
module tb_fp_compare_unit;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready, flag_nv;
  logic [31:0] op_a, op_b, result;
  logic [2:0]  op;
  logic [15:0] nv_count;

  fp_compare_unit #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op(op), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .flag_nv(flag_nv), .nv_count(nv_count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] res; logic nv; int acc; } exp_t;
  exp_t sb[$];
  int   tests = 0, fails = 0, cyc = 0, exp_cnt = 0;
  bit   chk_lat = 0;

  logic [31:0] specials [12] = '{32'h00000000, 32'h80000000, 32'h3F800000, 32'hBF800000,
                                 32'h7F800000, 32'hFF800000, 32'h7FC00000, 32'h7F800001,
                                 32'h00000001, 32'h80400000, 32'h40000000, 32'hFFC00005};

  // Reference: values mapped onto a signed integer line; NaNs handled separately.
  function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic nv);
    logic   an, bn, as_, bs_, less_a;
    longint ka, kb;
    an  = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    bn  = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    as_ = an && !a[22];
    bs_ = bn && !b[22];
    ka  = a[31] ? -longint'({1'b0, a[30:0]}) : longint'({1'b0, a[30:0]});
    kb  = b[31] ? -longint'({1'b0, b[30:0]}) : longint'({1'b0, b[30:0]});
    r   = 32'h0;
    nv  = 1'b0;
    case (o)
      3'd0: if (an || bn) nv = 1'b1; else r[0] = (ka <= kb);
      3'd1: if (an || bn) nv = 1'b1; else r[0] = (ka < kb);
      3'd2: if (an || bn) nv = as_ || bs_; else r[0] = (ka == kb);
      3'd3, 3'd4: begin
        nv = as_ || bs_;
        if (an && bn)  r = 32'h7FC00000;
        else if (an)   r = b;
        else if (bn)   r = a;
        else begin
          less_a = (ka < kb) || (ka == kb && a[31] && !b[31]);
          r = ((o == 3'd3) == less_a) ? a : b;
        end
      end
`ifdef FPCMP_FCLASS_EN
      3'd5: begin
        if (an)                                 r[as_ ? 8 : 9] = 1'b1;
        else if (a[30:23] == 8'hFF)             r[a[31] ? 0 : 7] = 1'b1;
        else if (a[30:0] == 0)                  r[a[31] ? 3 : 4] = 1'b1;
        else if (a[30:23] == 8'h00)             r[a[31] ? 2 : 5] = 1'b1;
        else                                    r[a[31] ? 1 : 6] = 1'b1;
      end
`endif
      default: ;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Sample just after the inputs settle, score handshakes, then advance one cycle.
  task automatic step(output bit acc);
    exp_t        e;
    logic [31:0] r;
    logic        n;
    #1;
    acc = 1'b0;
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          tests++; fails++;
          $error("FAIL spurious_out: observed result %h with empty scoreboard", result);
        end else begin
          e = sb.pop_front();
          check("result", result, e.res);
          check("flag_nv", {31'b0, flag_nv}, {31'b0, e.nv});
          check("nv_count", {16'b0, nv_count}, exp_cnt);
          if (chk_lat) check("latency", cyc - e.acc, 2);
          if (e.nv && exp_cnt != 65535) exp_cnt++;
        end
      end
      if (in_valid && in_ready) begin
        acc = 1'b1;
        model(op, op_a, op_b, r, n);
        e.res = r; e.nv = n; e.acc = cyc;
        sb.push_back(e);
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic send(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    bit acc;
    op = o; op_a = a; op_b = b; in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step(acc);
      if (acc) break;
    end
    if (!acc) begin
      tests++; fails++;
      $error("FAIL accept_timeout: observed in_ready stuck low, expected accept");
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit acc;
    out_ready = 1'b1;
    for (int k = 0; k < 50 && sb.size() > 0; k++) step(acc);
    if (sb.size() != 0) begin
      tests++; fails++;
      $error("FAIL drain_timeout: observed %0d pending, expected 0", sb.size());
    end
  endtask

  initial begin
    bit          acc;
    logic [31:0] held_res;
    logic        held_nv;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = 3'd0; op_a = '0; op_b = '0;
    @(negedge clk);
    step(acc); step(acc);
    rst = 1'b0;
    #1;
    check("rst_out_valid", {31'b0, out_valid}, 32'h0);
    check("rst_result", result, 32'h0);
    check("rst_flag_nv", {31'b0, flag_nv}, 32'h0);
    check("rst_nv_count", {16'b0, nv_count}, 32'h0);
    check("rst_in_ready", {31'b0, in_ready}, 32'h1);

    // Directed operations back to back, latency checked on each.
    chk_lat = 1;
    send(3'd1, 32'hBF800000, 32'h3F800000);
    send(3'd2, 32'h00000000, 32'h80000000);
    send(3'd0, 32'h00000000, 32'h80000000);
    send(3'd1, 32'h7FC00000, 32'h3F800000);
    send(3'd2, 32'h7FC00000, 32'h3F800000);
    send(3'd3, 32'h7F800001, 32'h40000000);
    send(3'd4, 32'h7FC00000, 32'h7FC00000);
    send(3'd5, 32'hFF800000, 32'h00000000);
    send(3'd3, 32'h80000000, 32'h00000000);
    send(3'd4, 32'h80000000, 32'h00000000);
    send(3'd1, 32'hBF800000, 32'hC0000000);
    send(3'd0, 32'h40000000, 32'h40000000);
    send(3'd2, 32'h7F800001, 32'h7F800001);
    send(3'd6, 32'h3F800000, 32'h3F800000);
    send(3'd7, 32'h7F800001, 32'h7F800001);
    drain();
    check("nv_count_directed", {16'b0, nv_count}, exp_cnt);

    // Backpressure: two accepted, third stalls while output holds.
    chk_lat = 0;
    out_ready = 1'b0;
    in_valid = 1'b1;
    op = 3'd4; op_a = 32'h3F800000; op_b = 32'h40000000; step(acc);
    check("bp_accept1", {31'b0, acc}, 32'h1);
    op = 3'd1; op_a = 32'h7FC00000; op_b = 32'h00000000; step(acc);
    check("bp_accept2", {31'b0, acc}, 32'h1);
    op = 3'd3; op_a = 32'hC0000000; op_b = 32'h3F800000;
    #1;
    check("bp_in_ready_low", {31'b0, in_ready}, 32'h0);
    held_res = result; held_nv = flag_nv;
    step(acc); step(acc);
    check("bp_out_valid", {31'b0, out_valid}, 32'h1);
    check("bp_result_stable", result, held_res);
    check("bp_flag_stable", {31'b0, flag_nv}, {31'b0, held_nv});
    out_ready = 1'b1;
    for (int k = 0; k < 10 && !acc; k++) step(acc);
    check("bp_accept3", {31'b0, acc}, 32'h1);
    in_valid = 1'b0;
    drain();

    // Random traffic with random backpressure.
    for (int k = 0; k < 300; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      op        = 3'($urandom_range(0, 7));
      op_a      = specials[$urandom_range(0, 11)];
      op_b      = specials[$urandom_range(0, 11)];
      step(acc);
    end
    in_valid = 1'b0;
    drain();
    check("nv_count_random", {16'b0, nv_count}, exp_cnt);

    // Reset in flight discards pending work.
    out_ready = 1'b0;
    send(3'd1, 32'h7FC00000, 32'h0);
    send(3'd1, 32'h7FC00000, 32'h0);
    rst = 1'b1; in_valid = 1'b1;
    step(acc);
    rst = 1'b0; in_valid = 1'b0;
    sb.delete();
    exp_cnt = 0;
    #1;
    check("mid_rst_out_valid", {31'b0, out_valid}, 32'h0);
    check("mid_rst_nv_count", {16'b0, nv_count}, 32'h0);
    check("mid_rst_in_ready", {31'b0, in_ready}, 32'h1);
    step(acc); step(acc);
    check("mid_rst_no_ghost", {31'b0, out_valid}, 32'h0);
    out_ready = 1'b1;
    send(3'd4, 32'hC0000000, 32'hBF800000);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no completion, expected $finish");
    $fatal(1, "watchdog expired");
  end
endmodule
